// File: rtl/capture_sink.sv
// rtl/capture_sink.sv - armed valid/ready word capture into block RAM, one-shot or circular
module capture_sink #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              full;
    logic              accept;
    logic              start;

    assign full   = (wr_count == FULL_COUNT);
    assign accept = in_valid && in_ready;
    assign start  = (state != S_CAPTURE) && arm;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stop outranks arm in CAPTURE because arm is only honoured outside it
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (stop) begin
                    state_next = S_DONE;
                end else if (WRAP == 0 && accept && wr_count == LAST_COUNT) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == S_CAPTURE);
        done     = (state == S_DONE);
        in_ready = busy && !(WRAP == 0 && full);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            wr_count <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            wr_ptr   <= '0;
            wr_count <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!full) begin
                wr_count <= wr_count + 1'b1;
            end
            if (WRAP != 0 && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset so a capture survives a reset for read-back
    always_ff @(posedge clk) begin
        if (accept && reset) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_capture_sink.sv
// tb/tb_capture_sink.sv - scoreboard bench for capture_sink in one-shot and circular modes
module tb_capture_sink;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       arm0 = 0, stop0 = 0, v0 = 0;
    logic [7:0] d0 = 0, ra0 = 0;
    logic       rdy0, busy0, done0, ovf0;
    logic [7:0] rd0, wp0;
    logic [8:0] wc0;

    logic       arm1 = 0, stop1 = 0, v1 = 0;
    logic [7:0] d1 = 0, ra1 = 0;
    logic       rdy1, busy1, done1, ovf1;
    logic [7:0] rd1, wp1;
    logic [8:0] wc1;

    capture_sink #(.DATA_W(8), .DEPTH(256), .ADDR_W(8), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .arm(arm0), .stop(stop0),
        .in_valid(v0), .in_data(d0), .in_ready(rdy0),
        .rd_addr(ra0), .rd_data(rd0), .wr_ptr(wp0), .wr_count(wc0),
        .busy(busy0), .done(done0), .overflow(ovf0)
    );

    capture_sink #(.DATA_W(8), .DEPTH(256), .ADDR_W(8), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .arm(arm1), .stop(stop1),
        .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .rd_addr(ra1), .rd_data(rd1), .wr_ptr(wp1), .wr_count(wc1),
        .busy(busy1), .done(done1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    localparam int SEL_RDY = 0, SEL_WC = 1, SEL_WP = 2, SEL_BUSY = 3,
                   SEL_DONE = 4, SEL_OVF = 5, SEL_RD = 6;

    typedef struct {
        string       name;
        int          dut;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] actual(input int dut, input int sel);
        logic [31:0] r;
        r = 'x;
        if (dut == 0) begin
            case (sel)
                SEL_RDY:  r = 32'(rdy0);
                SEL_WC:   r = 32'(wc0);
                SEL_WP:   r = 32'(wp0);
                SEL_BUSY: r = 32'(busy0);
                SEL_DONE: r = 32'(done0);
                SEL_OVF:  r = 32'(ovf0);
                SEL_RD:   r = 32'(rd0);
                default:  r = 'x;
            endcase
        end else begin
            case (sel)
                SEL_RDY:  r = 32'(rdy1);
                SEL_WC:   r = 32'(wc1);
                SEL_WP:   r = 32'(wp1);
                SEL_BUSY: r = 32'(busy1);
                SEL_DONE: r = 32'(done1);
                SEL_OVF:  r = 32'(ovf1);
                SEL_RD:   r = 32'(rd1);
                default:  r = 'x;
            endcase
        end
        return r;
    endfunction

    // Monitor: outputs are all register-driven, so the falling edge is a stable sample point
    always @(negedge clk) begin
        chk_t c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            act = actual(c.dut, c.sel);
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int dut, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.dut  = dut;
        c.sel  = sel;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset
        tick();
        tick();
        expect_val("rst_rd_data", 0, SEL_RD, 0);
        expect_val("rst_wr_count", 0, SEL_WC, 0);
        expect_val("rst_wr_ptr", 0, SEL_WP, 0);
        expect_val("rst_in_ready", 0, SEL_RDY, 0);
        expect_val("rst_busy", 0, SEL_BUSY, 0);
        expect_val("rst_done", 0, SEL_DONE, 0);
        expect_val("rst_overflow1", 1, SEL_OVF, 0);
        tick();
        reset = 1'b1;
        tick();
        expect_val("idle_in_ready", 0, SEL_RDY, 0);
        expect_val("idle_done", 0, SEL_DONE, 0);

        // 2: one-shot fill of 256 words
        arm0 = 1;
        tick();
        arm0 = 0;
        expect_val("arm_busy", 0, SEL_BUSY, 1);
        expect_val("arm_in_ready", 0, SEL_RDY, 1);
        v0 = 1;
        for (int i = 0; i < 256; i++) begin
            d0 = 8'(i);
            tick();
        end
        v0 = 0;
        expect_val("full_done", 0, SEL_DONE, 1);
        expect_val("full_busy", 0, SEL_BUSY, 0);
        expect_val("full_in_ready", 0, SEL_RDY, 0);
        expect_val("full_wr_count", 0, SEL_WC, 256);
        expect_val("full_wr_ptr", 0, SEL_WP, 0);
        ra0 = 8'h10;
        tick();
        expect_val("full_rd_10", 0, SEL_RD, 32'h10);
        ra0 = 8'hFF;
        tick();
        expect_val("full_rd_ff", 0, SEL_RD, 32'hFF);

        // 3: early stop coincident with the last word
        arm0 = 1;
        tick();
        arm0 = 0;
        v0 = 1;
        for (int i = 0; i < 5; i++) begin
            d0 = 8'(8'hA0 + i);
            stop0 = (i == 4);
            tick();
        end
        v0 = 0;
        stop0 = 0;
        expect_val("stop_done", 0, SEL_DONE, 1);
        expect_val("stop_wr_count", 0, SEL_WC, 5);
        expect_val("stop_wr_ptr", 0, SEL_WP, 5);
        d0 = 8'hA5;
        v0 = 1;
        tick();
        v0 = 0;
        expect_val("stop_drop_wr_count", 0, SEL_WC, 5);
        ra0 = 8'd4;
        tick();
        expect_val("stop_rd_4", 0, SEL_RD, 32'hA4);
        ra0 = 8'd5;
        tick();
        expect_val("stop_rd_5_unchanged", 0, SEL_RD, 32'h05);

        // 5: gapped valid
        arm0 = 1;
        tick();
        arm0 = 0;
        for (int c = 0; c < 8; c++) begin
            v0 = (c % 2 == 0);
            d0 = 8'(8'h30 + c);
            tick();
        end
        v0 = 0;
        expect_val("gap_wr_ptr", 0, SEL_WP, 4);
        expect_val("gap_wr_count", 0, SEL_WC, 4);
        expect_val("gap_busy", 0, SEL_BUSY, 1);
        ra0 = 8'd1;
        tick();
        expect_val("gap_rd_1", 0, SEL_RD, 32'h32);
        ra0 = 8'd3;
        stop0 = 1;
        arm0 = 1;
        tick();
        stop0 = 0;
        arm0 = 0;
        expect_val("gap_rd_3", 0, SEL_RD, 32'h36);
        expect_val("stop_beats_arm_done", 0, SEL_DONE, 1);

        // 4: circular capture of 300 words
        arm1 = 1;
        tick();
        arm1 = 0;
        v1 = 1;
        for (int i = 0; i < 300; i++) begin
            d1 = 8'(i);
            tick();
            if (i == 255) begin
                expect_val("wrap_at_full_count", 1, SEL_WC, 256);
                expect_val("wrap_at_full_ovf", 1, SEL_OVF, 0);
                expect_val("wrap_at_full_ready", 1, SEL_RDY, 1);
            end
            if (i == 256) begin
                expect_val("wrap_first_overwrite_ovf", 1, SEL_OVF, 1);
            end
        end
        v1 = 0;
        stop1 = 1;
        tick();
        stop1 = 0;
        expect_val("wrap_done", 1, SEL_DONE, 1);
        expect_val("wrap_wr_count", 1, SEL_WC, 256);
        expect_val("wrap_overflow", 1, SEL_OVF, 1);
        expect_val("wrap_wr_ptr", 1, SEL_WP, 44);
        ra1 = 8'd0;
        tick();
        expect_val("wrap_rd_0", 1, SEL_RD, 32'h00);
        ra1 = 8'd44;
        tick();
        expect_val("wrap_rd_44", 1, SEL_RD, 32'h2C);
        arm1 = 1;
        tick();
        arm1 = 0;
        expect_val("wrap_rearm_ovf_clear", 1, SEL_OVF, 0);
        expect_val("wrap_rearm_count_clear", 1, SEL_WC, 0);

        // 6: reset mid-capture keeps memory, clears counters
        arm0 = 1;
        tick();
        arm0 = 0;
        v0 = 1;
        for (int i = 0; i < 10; i++) begin
            d0 = 8'(8'h50 + i);
            tick();
        end
        v0 = 0;
        expect_val("mid_wr_count_pre", 0, SEL_WC, 10);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_val("mid_rst_busy", 0, SEL_BUSY, 0);
        expect_val("mid_rst_done", 0, SEL_DONE, 0);
        expect_val("mid_rst_wr_count", 0, SEL_WC, 0);
        expect_val("mid_rst_wr_ptr", 0, SEL_WP, 0);
        for (int i = 0; i < 10; i++) begin
            ra0 = 8'(i);
            tick();
            expect_val($sformatf("mid_rd_%0d", i), 0, SEL_RD, 32'(8'h50 + i));
        end
        arm0 = 1;
        tick();
        arm0 = 0;
        d0 = 8'hEE;
        v0 = 1;
        tick();
        v0 = 0;
        expect_val("rearm_wr_ptr", 0, SEL_WP, 1);
        expect_val("rearm_wr_count", 0, SEL_WC, 1);
        ra0 = 8'd0;
        tick();
        expect_val("rearm_rd_0", 0, SEL_RD, 32'hEE);
        ra0 = 8'd1;
        tick();
        expect_val("rearm_rd_1_kept", 0, SEL_RD, 32'h51);

        repeat (3) tick();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
